// File: rtl/f_fetch_unit.sv
// Fetch stage and F/D pipeline register for the five-stage MIPS core.
// Chooses the next PC, flags misaligned or out-of-range fetches (AdEL) and registers F into D.
module f_fetch_unit #(
   parameter logic [31:0] PC_INIT   = 32'h0000_3000,
   parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
   parameter logic [31:0] IM_BASE   = 32'h0000_3000,
   parameter logic [31:0] IM_END    = 32'h0000_6FFC
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] F_Instr,
   input  logic        F_Stall,
   input  logic [1:0]  D_NPCOp,
   input  logic        D_BrTaken,
   input  logic [31:0] D_Imm32,
   input  logic [31:0] D_RsData,
   input  logic        D_Eret,
   input  logic [31:0] EPC,
   input  logic        Req,
   output logic [31:0] F_PC,
   output logic [31:0] D_PC,
   output logic [31:0] D_Instr,
   output logic [4:0]  D_ExcCode,
   output logic        D_BD
);

   typedef enum logic [1:0] {
      NPC_SEQ = 2'd0,
      NPC_BR  = 2'd1,
      NPC_J   = 2'd2,
      NPC_JR  = 2'd3
   } npc_op_e;

   localparam logic [4:0] EXC_NONE = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;

   function automatic logic fetch_adel(input logic [31:0] pc);
      return (pc[1:0] != 2'b00) || (pc < IM_BASE) || (pc > IM_END);
   endfunction

   function automatic logic [31:0] branch_target(input logic [31:0] pc,
                                                 input logic [31:0] imm);
      return pc + 32'd4 + {imm[29:0], 2'b00};
   endfunction

   function automatic logic [31:0] jump_target(input logic [31:0] pc,
                                               input logic [31:0] instr);
      return {pc[31:28], instr[25:0], 2'b00};
   endfunction

   logic [31:0] f_pc_q, f_pc_d;
   logic [31:0] d_pc_q, d_pc_d;
   logic [31:0] d_instr_q, d_instr_d;
   logic [4:0]  d_exc_q, d_exc_d;
   logic        d_bd_q, d_bd_d;
   logic [31:0] npc;
   logic        f_adel;
   npc_op_e     npc_op;

   assign npc_op = npc_op_e'(D_NPCOp);
   assign f_adel = fetch_adel(f_pc_q);

   // eret outranks every D-stage control transfer
   always_comb begin
      npc = f_pc_q + 32'd4;
      if (D_Eret) begin
         npc = EPC;
      end else begin
         case (npc_op)
            NPC_JR:  npc = D_RsData;
            NPC_J:   npc = jump_target(d_pc_q, d_instr_q);
            NPC_BR:  npc = D_BrTaken ? branch_target(d_pc_q, D_Imm32) : f_pc_q + 32'd4;
            default: npc = f_pc_q + 32'd4;
         endcase
      end
   end

   always_comb begin
      f_pc_d    = f_pc_q;
      d_pc_d    = d_pc_q;
      d_instr_d = d_instr_q;
      d_exc_d   = d_exc_q;
      d_bd_d    = d_bd_q;
      if (Req) begin
         f_pc_d    = EXC_ENTRY;
         d_pc_d    = EXC_ENTRY;
         d_instr_d = 32'd0;
         d_exc_d   = EXC_NONE;
         d_bd_d    = 1'b0;
      end else if (!F_Stall) begin
         f_pc_d = npc;
         d_pc_d = f_pc_q;
         d_bd_d = (D_NPCOp != 2'd0);
         if (f_adel) begin
            d_instr_d = 32'd0;
            d_exc_d   = EXC_ADEL;
         end else if (D_Eret) begin
            // eret has no delay slot: the fetched instruction is squashed
            d_instr_d = 32'd0;
            d_exc_d   = EXC_NONE;
            d_bd_d    = 1'b0;
         end else begin
            d_instr_d = F_Instr;
            d_exc_d   = EXC_NONE;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         f_pc_q    <= PC_INIT;
         d_pc_q    <= 32'd0;
         d_instr_q <= 32'd0;
         d_exc_q   <= EXC_NONE;
         d_bd_q    <= 1'b0;
      end else begin
         f_pc_q    <= f_pc_d;
         d_pc_q    <= d_pc_d;
         d_instr_q <= d_instr_d;
         d_exc_q   <= d_exc_d;
         d_bd_q    <= d_bd_d;
      end
   end

   assign F_PC      = f_pc_q;
   assign D_PC      = d_pc_q;
   assign D_Instr   = d_instr_q;
   assign D_ExcCode = d_exc_q;
   assign D_BD      = d_bd_q;

endmodule

// File: tb/tb_f_fetch_unit.sv
// Bench for f_fetch_unit: directed scenarios plus randomized traffic against a next-PC model.
module tb_f_fetch_unit;

   localparam logic [31:0] PC_INIT   = 32'h0000_3000;
   localparam logic [31:0] EXC_ENTRY = 32'h0000_4180;
   localparam logic [31:0] IM_BASE   = 32'h0000_3000;
   localparam logic [31:0] IM_END    = 32'h0000_6FFC;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] F_Instr;
   logic        F_Stall;
   logic [1:0]  D_NPCOp;
   logic        D_BrTaken;
   logic [31:0] D_Imm32;
   logic [31:0] D_RsData;
   logic        D_Eret;
   logic [31:0] EPC;
   logic        Req;
   logic [31:0] F_PC;
   logic [31:0] D_PC;
   logic [31:0] D_Instr;
   logic [4:0]  D_ExcCode;
   logic        D_BD;

   int checks = 0;
   int failures = 0;

   logic [31:0] m_fpc, m_dpc, m_dinstr;
   logic [4:0]  m_exc;
   logic        m_bd;

   f_fetch_unit dut (
      .clk(clk), .reset(reset), .F_Instr(F_Instr), .F_Stall(F_Stall),
      .D_NPCOp(D_NPCOp), .D_BrTaken(D_BrTaken), .D_Imm32(D_Imm32),
      .D_RsData(D_RsData), .D_Eret(D_Eret), .EPC(EPC), .Req(Req),
      .F_PC(F_PC), .D_PC(D_PC), .D_Instr(D_Instr), .D_ExcCode(D_ExcCode), .D_BD(D_BD)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] im_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
   endfunction

   assign F_Instr = im_word(F_PC);

   task automatic idle();
      F_Stall = 0; D_NPCOp = 0; D_BrTaken = 0; D_Imm32 = 0;
      D_RsData = 0; D_Eret = 0; EPC = 0; Req = 0;
   endtask

   task automatic model_reset();
      m_fpc = PC_INIT; m_dpc = 0; m_dinstr = 0; m_exc = 0; m_bd = 0;
   endtask

   // Advance one clock; the model follows the fetch rules using the inputs present before the edge.
   task automatic tick();
      logic [31:0] npc;
      logic        bad;
      bad = (m_fpc % 4 != 0) || (m_fpc < IM_BASE) || (m_fpc > IM_END);
      if (D_Eret)                         npc = EPC;
      else if (D_NPCOp == 3)              npc = D_RsData;
      else if (D_NPCOp == 2)              npc = (m_dpc & 32'hF000_0000) | ((m_dinstr & 32'h03FF_FFFF) * 4);
      else if (D_NPCOp == 1 && D_BrTaken) npc = m_dpc + 4 + D_Imm32 * 4;
      else                                npc = m_fpc + 4;
      @(posedge clk);
      #1;
      if (reset) begin
         model_reset();
      end else if (Req) begin
         m_fpc = EXC_ENTRY; m_dpc = EXC_ENTRY; m_dinstr = 0; m_exc = 0; m_bd = 0;
      end else if (!F_Stall) begin
         m_dpc = m_fpc;
         m_bd  = (D_NPCOp != 0);
         if (bad) begin
            m_dinstr = 0; m_exc = 4;
         end else if (D_Eret) begin
            m_dinstr = 0; m_exc = 0; m_bd = 0;
         end else begin
            m_dinstr = im_word(m_fpc); m_exc = 0;
         end
         m_fpc = npc;
      end
   endtask

   task automatic test_reset();
      reset = 1; idle();
      #12;
      model_reset();
      checks++; if (F_PC !== PC_INIT) begin failures++; $display("FAIL rst_fpc got=%h exp=%h", F_PC, PC_INIT); end
      checks++; if (D_PC !== 32'd0) begin failures++; $display("FAIL rst_dpc got=%h exp=0", D_PC); end
      checks++; if (D_Instr !== 32'd0) begin failures++; $display("FAIL rst_dinstr got=%h exp=0", D_Instr); end
      checks++; if (D_ExcCode !== 5'd0) begin failures++; $display("FAIL rst_exc got=%0d exp=0", D_ExcCode); end
      checks++; if (D_BD !== 1'b0) begin failures++; $display("FAIL rst_bd got=%b exp=0", D_BD); end
      @(negedge clk);
      reset = 0;
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++; if (F_PC !== PC_INIT + 32'(4 * (k + 1))) begin failures++; $display("FAIL seq_fpc%0d got=%h exp=%h", k, F_PC, PC_INIT + 32'(4 * (k + 1))); end
         checks++; if (D_PC !== PC_INIT + 32'(4 * k)) begin failures++; $display("FAIL seq_dpc%0d got=%h exp=%h", k, D_PC, PC_INIT + 32'(4 * k)); end
         checks++; if (D_Instr !== im_word(PC_INIT + 32'(4 * k))) begin failures++; $display("FAIL seq_dinstr%0d got=%h exp=%h", k, D_Instr, im_word(PC_INIT + 32'(4 * k))); end
         checks++; if (D_BD !== 1'b0) begin failures++; $display("FAIL seq_bd%0d got=%b exp=0", k, D_BD); end
      end
   endtask

   task automatic test_branch();
      tick(); tick();
      checks++; if (D_PC !== 32'h3010) begin failures++; $display("FAIL br_setup got=%h exp=00003010", D_PC); end
      D_NPCOp = 1; D_BrTaken = 1; D_Imm32 = 32'h0000_0004;
      tick();
      checks++; if (F_PC !== 32'h3024) begin failures++; $display("FAIL br_fpc got=%h exp=00003024", F_PC); end
      checks++; if (D_PC !== 32'h3014) begin failures++; $display("FAIL br_slot_pc got=%h exp=00003014", D_PC); end
      checks++; if (D_BD !== 1'b1) begin failures++; $display("FAIL br_slot_bd got=%b exp=1", D_BD); end
      checks++; if (D_Instr !== im_word(32'h3014)) begin failures++; $display("FAIL br_slot_instr got=%h exp=%h", D_Instr, im_word(32'h3014)); end
      idle();
   endtask

   task automatic test_jr_adel();
      D_NPCOp = 3; D_RsData = 32'h0000_3002;
      tick();
      checks++; if (F_PC !== 32'h3002) begin failures++; $display("FAIL jr_fpc got=%h exp=00003002", F_PC); end
      idle();
      tick();
      checks++; if (D_ExcCode !== 5'd4) begin failures++; $display("FAIL jr_adel_exc got=%0d exp=4", D_ExcCode); end
      checks++; if (D_Instr !== 32'd0) begin failures++; $display("FAIL jr_adel_instr got=%h exp=0", D_Instr); end
      checks++; if (D_PC !== 32'h3002) begin failures++; $display("FAIL jr_adel_pc got=%h exp=00003002", D_PC); end
      tick();
      checks++; if (D_ExcCode !== 5'd4) begin failures++; $display("FAIL jr_adel2_exc got=%0d exp=4", D_ExcCode); end
   endtask

   task automatic test_stall_req();
      reset = 1; #1; reset = 0; model_reset(); idle();
      for (int k = 0; k < 8; k++) tick();
      checks++; if (F_PC !== 32'h3020) begin failures++; $display("FAIL st_setup got=%h exp=00003020", F_PC); end
      F_Stall = 1; D_NPCOp = 1; D_BrTaken = 1; D_Imm32 = 32'h40;
      for (int k = 0; k < 2; k++) begin
         tick();
         checks++; if (F_PC !== 32'h3020) begin failures++; $display("FAIL st_fpc%0d got=%h exp=00003020", k, F_PC); end
         checks++; if (D_PC !== 32'h301C) begin failures++; $display("FAIL st_dpc%0d got=%h exp=0000301c", k, D_PC); end
         checks++; if (D_Instr !== im_word(32'h301C)) begin failures++; $display("FAIL st_dinstr%0d got=%h exp=%h", k, D_Instr, im_word(32'h301C)); end
      end
      Req = 1; D_Eret = 1; EPC = 32'h3100;
      tick();
      checks++; if (F_PC !== EXC_ENTRY) begin failures++; $display("FAIL req_fpc got=%h exp=%h", F_PC, EXC_ENTRY); end
      checks++; if (D_PC !== EXC_ENTRY) begin failures++; $display("FAIL req_dpc got=%h exp=%h", D_PC, EXC_ENTRY); end
      checks++; if (D_Instr !== 32'd0) begin failures++; $display("FAIL req_dinstr got=%h exp=0", D_Instr); end
      checks++; if (D_BD !== 1'b0) begin failures++; $display("FAIL req_bd got=%b exp=0", D_BD); end
      idle();
   endtask

   task automatic test_stall_release_branch();
      tick();
      F_Stall = 1; D_NPCOp = 1; D_BrTaken = 1; D_Imm32 = 32'hFFFF_FFFE;
      tick();
      checks++; if (F_PC !== 32'h4184) begin failures++; $display("FAIL rel_hold got=%h exp=00004184", F_PC); end
      F_Stall = 0;
      tick();
      checks++; if (F_PC !== 32'h417C) begin failures++; $display("FAIL rel_redirect got=%h exp=0000417c", F_PC); end
      checks++; if (D_BD !== 1'b1) begin failures++; $display("FAIL rel_bd got=%b exp=1", D_BD); end
      idle();
   endtask

   task automatic test_eret();
      tick();
      D_Eret = 1; EPC = 32'h3100; D_NPCOp = 0;
      tick();
      checks++; if (F_PC !== 32'h3100) begin failures++; $display("FAIL eret_fpc got=%h exp=00003100", F_PC); end
      checks++; if (D_Instr !== 32'd0) begin failures++; $display("FAIL eret_instr got=%h exp=0", D_Instr); end
      checks++; if (D_BD !== 1'b0) begin failures++; $display("FAIL eret_bd got=%b exp=0", D_BD); end
      checks++; if (D_PC !== m_dpc) begin failures++; $display("FAIL eret_dpc got=%h exp=%h", D_PC, m_dpc); end
      idle();
   endtask

   task automatic test_async_reset();
      @(posedge clk); #3;
      reset = 1;
      #1;
      model_reset();
      checks++; if (F_PC !== PC_INIT) begin failures++; $display("FAIL arst_fpc got=%h exp=%h", F_PC, PC_INIT); end
      checks++; if (D_PC !== 32'd0) begin failures++; $display("FAIL arst_dpc got=%h exp=0", D_PC); end
      checks++; if (D_Instr !== 32'd0) begin failures++; $display("FAIL arst_dinstr got=%h exp=0", D_Instr); end
      reset = 0;
      tick();
      checks++; if (F_PC !== PC_INIT + 4) begin failures++; $display("FAIL arst_resume got=%h exp=%h", F_PC, PC_INIT + 4); end
      checks++; if (D_PC !== PC_INIT) begin failures++; $display("FAIL arst_resume_dpc got=%h exp=%h", D_PC, PC_INIT); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         reset     = ($urandom_range(0, 63) == 0);
         Req       = ($urandom_range(0, 15) == 0);
         F_Stall   = ($urandom_range(0, 3) == 0);
         D_Eret    = ($urandom_range(0, 7) == 0);
         D_NPCOp   = 2'($urandom_range(0, 3));
         D_BrTaken = 1'($urandom_range(0, 1));
         D_Imm32   = 32'(int'($urandom_range(0, 63)) - 32);
         D_RsData  = ($urandom_range(0, 5) == 0) ? $urandom : IM_BASE + 4 * $urandom_range(0, 32'h0FFF);
         EPC       = ($urandom_range(0, 5) == 0) ? $urandom : IM_BASE + 4 * $urandom_range(0, 32'h0FFF);
         tick();
         checks++; if (F_PC !== m_fpc) begin failures++; $display("FAIL rnd_fpc it=%0d got=%h exp=%h", i, F_PC, m_fpc); end
         checks++; if (D_PC !== m_dpc) begin failures++; $display("FAIL rnd_dpc it=%0d got=%h exp=%h", i, D_PC, m_dpc); end
         checks++; if (D_Instr !== m_dinstr) begin failures++; $display("FAIL rnd_dinstr it=%0d got=%h exp=%h", i, D_Instr, m_dinstr); end
         checks++; if (D_ExcCode !== m_exc) begin failures++; $display("FAIL rnd_exc it=%0d got=%0d exp=%0d", i, D_ExcCode, m_exc); end
         checks++; if (D_BD !== m_bd) begin failures++; $display("FAIL rnd_bd it=%0d got=%b exp=%b", i, D_BD, m_bd); end
      end
      reset = 0; idle();
   endtask

   initial begin
      test_reset();
      test_branch();
      test_jr_adel();
      test_stall_req();
      test_stall_release_branch();
      test_eret();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/f_fetch_unit.md
# f_fetch_unit

Fetch stage plus F/D pipeline register of the five-stage MIPS core. Holds the PC, selects the next PC from D-stage branch/jump/eret decisions and the CP0 exception request, checks fetch addresses for AdEL, and registers the fetched instruction, its PC, exception code and delay-slot flag into D. Its D-stage outputs feed the decoder and immediate-extension unit; the sign-extended branch offset returns from that extension unit as an input.

## Interface
- PC_INIT, 32'h0000_3000, reset PC
- EXC_ENTRY, 32'h0000_4180, exception handler entry
- IM_BASE, 32'h0000_3000, lowest legal fetch address
- IM_END, 32'h0000_6FFC, highest legal fetch address
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- F_Instr  in  32  instruction read from IM at F_PC
- F_Stall  in  1  hazard stall: hold PC and F/D register
- D_NPCOp  in  2  D-instruction class: 0 sequential, 1 branch, 2 j/jal, 3 jr/jalr
- D_BrTaken  in  1  branch condition true (meaningful only when D_NPCOp==1)
- D_Imm32  in  32  sign-extended 16-bit offset of D instruction
- D_RsData  in  32  forwarded rs value for jr/jalr
- D_Eret  in  1  D instruction is eret
- EPC  in  32  CP0 EPC (forwarded)
- Req  in  1  CP0 exception/interrupt request
- F_PC  out  32  current fetch address to IM
- D_PC  out  32  PC of instruction in D
- D_Instr  out  32  instruction in D
- D_ExcCode  out  5  0 none, 4 AdEL
- D_BD  out  1  D instruction sits in a branch delay slot

## Operation
- Next-PC (combinational, priority high to low): D_Eret -> EPC; D_NPCOp==3 -> D_RsData; ==2 -> {D_PC[31:28], D_Instr[25:0], 2'b00}; ==1 and D_BrTaken -> D_PC + 4 + (D_Imm32 << 2); otherwise F_PC + 4. All adds 32-bit, wrap modulo 2^32.
- Fetch AdEL: F_PC[1:0] != 0, or F_PC < IM_BASE, or F_PC > IM_END.
- Per-edge update priority: reset > Req > F_Stall > normal.
- Req: F_PC <= EXC_ENTRY; D_Instr <= 0, D_PC <= EXC_ENTRY, D_ExcCode <= 0, D_BD <= 0. Overrides F_Stall.
- F_Stall (no Req): every register holds.
- Normal: F_PC <= next-PC; D_PC <= F_PC; D_BD <= (D_NPCOp != 0), regardless of taken.
  - AdEL: D_Instr <= 0, D_ExcCode <= 4.
  - D_Eret without AdEL: D_Instr <= 0, D_ExcCode <= 0 (eret has no delay slot; slot instruction squashed, D_BD <= 0).
  - Otherwise: D_Instr <= F_Instr, D_ExcCode <= 0.
- A bad jr target is not checked here; it is fetched next cycle and flagged AdEL then.

## Timing
- Reset (async, immediate): F_PC = PC_INIT; D_PC = 0, D_Instr = 0, D_ExcCode = 0, D_BD = 0.
- Reset deasserted mid-operation: first fetch at PC_INIT on the following edge; no residue from prior state.
- Latency: instruction at F_PC appears on D_* one cycle later; redirect by D-stage branch takes effect on the next edge (one delay slot, always executed).
- Next-PC logic depends on same-cycle D inputs; F_PC, D_* are pure register outputs.
- Stall released: next-PC evaluated against D inputs of that cycle; a branch in D held by stall redirects on the release edge only.
- Req and D_Eret simultaneously: Req wins.

## Test plan
- Reset, run 3 cycles with no redirect -> F_PC 0x3000, 0x3004, 0x3008; D_PC trails by one cycle; D_BD=0.
- D at 0x3010 beq, D_BrTaken=1, D_Imm32=0x0000_0004 -> next F_PC = 0x3024; slot instr (0x3014) enters D with D_BD=1.
- jr with D_RsData=0x0000_3002 -> F_PC 0x3002; next cycle D_ExcCode=4, D_Instr=0, D_PC=0x3002.
- F_Stall held 2 cycles at F_PC=0x3020 -> F_PC, D_PC, D_Instr unchanged; Req asserted during stall -> F_PC=0x4180, D_Instr=0, D_PC=0x4180.
- D_Eret with EPC=0x3100 -> F_PC=0x3100; D_Instr=0, D_BD=0 next cycle.
- Assert reset asynchronously mid-cycle -> outputs reach reset values before the next clock edge.
